// File: rtl/serial_bus_slave_burst.sv
// rtl/serial_bus_slave_burst.sv - serial bus slave with burst transfers to a local memory port
module serial_bus_slave_burst #(
    parameter int ID_WIDTH    = 3,
    parameter int SELF_ID     = 0,
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_in,
    output logic                  bus_out,
    output logic                  bus_oe,
    input  logic                  bus_util,
    input  logic                  arbiter_grant,
    output logic                  mem_we,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int H  = 2 + ID_WIDTH + BURST_WIDTH + ADDR_WIDTH;
    localparam int HB = H - 1;
    localparam int CW = $clog2(H + DATA_WIDTH + TIMEOUT + 4);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_SKIP, S_ACK, S_WR_WAIT, S_WR_DATA, S_WR_MEM,
        S_WR_GRANT, S_WR_ACK, S_RD_MEM, S_RD_GRANT, S_RD_TX
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt;
    logic [HB-2:0]          hdr;
    logic [BURST_WIDTH-1:0] beats;
    logic [DATA_WIDTH-1:0]  data_sr;

    // The oldest header bit drops out on the final shift; it has been compared by then.
    logic [ID_WIDTH-1:0]    hdr_id;
    logic                   hdr_dir;
    logic [BURST_WIDTH-1:0] hdr_len;
    logic [ADDR_WIDTH-1:0]  hdr_addr;

    assign hdr_id   = hdr[HB-2 -: ID_WIDTH];
    assign hdr_dir  = hdr[ADDR_WIDTH+BURST_WIDTH];
    assign hdr_len  = hdr[ADDR_WIDTH +: BURST_WIDTH];
    assign hdr_addr = hdr[ADDR_WIDTH-1:0];

    always_comb begin
        state_n = state;
        bus_oe  = 1'b0;
        bus_out = 1'b1;
        case (state)
            S_IDLE:     if (!bus_in) state_n = S_HDR;
            S_HDR:      if (cnt == CW'(HB - 1))
                            state_n = (hdr_id == ID_WIDTH'(SELF_ID)) ? S_ACK : S_SKIP;
            S_SKIP:     if (bus_util) state_n = S_IDLE;
            S_ACK: begin
                bus_oe  = 1'b1;
                bus_out = 1'b0;
                if (cnt == CW'(1)) state_n = hdr_dir ? S_WR_WAIT : S_RD_MEM;
            end
            S_WR_WAIT: begin
                if (!bus_in)                       state_n = S_WR_DATA;
                else if (cnt == CW'(TIMEOUT - 1))  state_n = S_IDLE;
            end
            S_WR_DATA:  if (cnt == CW'(DATA_WIDTH - 1)) state_n = S_WR_MEM;
            S_WR_MEM:   if (mem_ack && !mem_we) state_n = S_WR_GRANT;
            S_WR_GRANT: if (arbiter_grant) state_n = S_WR_ACK;
            S_WR_ACK: begin
                bus_oe  = 1'b1;
                bus_out = (cnt == CW'(2));
                if (cnt == CW'(2)) state_n = (beats == '0) ? S_IDLE : S_WR_WAIT;
            end
            S_RD_MEM:   if (mem_ack && !mem_req) state_n = S_RD_GRANT;
            S_RD_GRANT: if (arbiter_grant) state_n = S_RD_TX;
            S_RD_TX: begin
                bus_oe = 1'b1;
                if (cnt == '0)                          bus_out = 1'b0;
                else if (cnt == CW'(DATA_WIDTH + 1))    bus_out = 1'b1;
                else                                    bus_out = data_sr[DATA_WIDTH-1];
                if (cnt == CW'(DATA_WIDTH + 1)) state_n = (beats == '0) ? S_IDLE : S_RD_MEM;
            end
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hdr       <= '0;
            beats     <= '0;
            data_sr   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= (state_n != state) ? '0 : cnt + 1'b1;
            mem_we  <= 1'b0;
            mem_req <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_HDR: hdr <= {hdr[HB-3:0], bus_in};
                S_ACK: if (state_n != state) begin
                    mem_addr <= hdr_addr;
                    beats    <= hdr_len;
                    mem_req  <= !hdr_dir;
                    busy     <= busy | !hdr_dir;
                end
                S_WR_WAIT: if (state_n == S_IDLE) begin
                    err  <= 1'b1;
                    busy <= 1'b0;
                end
                S_WR_DATA: begin
                    data_sr <= {data_sr[DATA_WIDTH-2:0], bus_in};
                    if (state_n == S_WR_MEM) begin
                        mem_wdata <= {data_sr[DATA_WIDTH-2:0], bus_in};
                        mem_we    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_WR_MEM: if (state_n == S_WR_GRANT && beats == '0) busy <= 1'b0;
                S_WR_ACK: if (state_n != state) begin
                    if (beats == '0) begin
                        done <= 1'b1;
                    end else begin
                        beats    <= beats - 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                S_RD_MEM: if (state_n == S_RD_GRANT) begin
                    data_sr <= mem_rdata;
                    if (beats == '0) busy <= 1'b0;
                end
                S_RD_TX: begin
                    if (cnt != '0 && cnt <= CW'(DATA_WIDTH)) data_sr <= data_sr << 1;
                    if (state_n != state) begin
                        if (beats == '0) begin
                            done <= 1'b1;
                        end else begin
                            beats    <= beats - 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                            mem_req  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_bus_slave_burst.sv
// tb/tb_serial_bus_slave_burst.sv - self-checking bench for serial_bus_slave_burst
module tb_serial_bus_slave_burst;
    localparam int IDW = 3;
    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int BW  = 2;
    localparam int TO  = 16;
    localparam int ASPACE = 1 << AW;

    logic clk = 1'b0;
    logic rst, bus_in, bus_out, bus_oe, bus_util, arbiter_grant;
    logic mem_we, mem_req, mem_ack, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0, errors = 0;
    int exp_done = 0, exp_err = 0;
    int we_cnt = 0, req_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_cnt = 0;

    serial_bus_slave_burst #(
        .ID_WIDTH(IDW), .SELF_ID(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_WIDTH(BW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .bus_util(bus_util), .arbiter_grant(arbiter_grant), .mem_we(mem_we),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1)  we_cnt   <= we_cnt + 1;
        if (mem_req === 1'b1) req_cnt  <= req_cnt + 1;
        if (done === 1'b1)    done_cnt <= done_cnt + 1;
        if (err === 1'b1)     err_cnt  <= err_cnt + 1;
        if (bus_oe === 1'b1)  oe_cnt   <= oe_cnt + 1;
        if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus_in = b;
        tick();
    endtask

    task automatic send_hdr(input int id, input int dir, input int len, input int addr);
        send_bit(1'b0);
        for (int i = IDW - 1; i >= 0; i--) send_bit(id[i]);
        send_bit(dir[0]);
        for (int i = BW - 1; i >= 0; i--) send_bit(len[i]);
        for (int i = AW - 1; i >= 0; i--) send_bit(addr[i]);
        bus_in = 1'b1;
    endtask

    task automatic expect_ack();
        check("ack0_oe", bus_oe, 1);
        check("ack0_out", bus_out, 0);
        tick();
        check("ack1_oe", bus_oe, 1);
        check("ack1_out", bus_out, 0);
        tick();
        check("ack_release", bus_oe, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_oe"}, bus_oe, 0);
        check({tag, "_out"}, bus_out, 1);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic write_beat(input int exp_addr, input logic [DW-1:0] d, input bit last, input bit early);
        send_bit(1'b0);
        for (int i = DW - 1; i >= 0; i--) send_bit(d[i]);
        bus_in = 1'b1;
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, exp_addr);
        check("wr_data", mem_wdata, d);
        check("wr_busy", busy, 1);
        tick();
        check("wr_we_pulse", mem_we, 0);
        if (early) begin
            arbiter_grant = 1'b1;
            tick();
            arbiter_grant = 1'b0;
        end
        repeat ($urandom_range(0, 2)) tick();
        check("wr_no_drive", bus_oe, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_busy_after_ack", busy, !last);
        repeat ($urandom_range(0, 3)) tick();
        check("wr_wait_grant", bus_oe, 0);
        arbiter_grant = 1'b1;
        tick();
        arbiter_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wr_ack_oe", bus_oe, 1);
            check("wr_ack_out", bus_out, (k == 2) ? 1 : 0);
            tick();
        end
        check("wr_ack_release", bus_oe, 0);
        check("wr_done", done, last);
    endtask

    task automatic read_beat(input int exp_addr, input logic [DW-1:0] d, input bit last);
        logic [DW+1:0] seen;
        check("rd_req", mem_req, 1);
        check("rd_addr", mem_addr, exp_addr);
        check("rd_busy", busy, 1);
        tick();
        check("rd_req_pulse", mem_req, 0);
        repeat ($urandom_range(0, 2)) tick();
        mem_rdata = d;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rdata = DW'($urandom);
        check("rd_busy_after_ack", busy, !last);
        repeat ($urandom_range(0, 3)) tick();
        check("rd_wait_grant", bus_oe, 0);
        arbiter_grant = 1'b1;
        tick();
        arbiter_grant = 1'b0;
        seen = '0;
        for (int k = 0; k < DW + 2; k++) begin
            check("rd_tx_oe", bus_oe, 1);
            seen = {seen[DW:0], bus_out};
            tick();
        end
        check("rd_frame", seen, {1'b0, d, 1'b1});
        check("rd_release", bus_oe, 0);
        check("rd_done", done, last);
    endtask

    task automatic do_write(input int addr, input int len, input logic [DW-1:0] d [4], input bit early);
        int we0;
        we0 = we_cnt;
        send_hdr(0, 1, len, addr);
        expect_ack();
        for (int b = 0; b <= len; b++) write_beat((addr + b) % ASPACE, d[b], b == len, early);
        check("wr_strobe_count", we_cnt - we0, len + 1);
        exp_done++;
    endtask

    task automatic do_read(input int addr, input int len, input logic [DW-1:0] d [4]);
        int req0;
        req0 = req_cnt;
        send_hdr(0, 0, len, addr);
        expect_ack();
        for (int b = 0; b <= len; b++) read_beat((addr + b) % ASPACE, d[b], b == len);
        check("rd_strobe_count", req_cnt - req0, len + 1);
        exp_done++;
    endtask

    task automatic silent_timeout();
        for (int i = 1; i < TO; i++) begin
            tick();
            check("to_early_err", err, 0);
        end
        tick();
        check("to_err", err, 1);
        check("to_done", done, 0);
        check("to_busy", busy, 0);
        check("to_oe", bus_oe, 0);
        tick();
        check("to_err_pulse", err, 0);
        exp_err++;
    endtask

    initial begin
        logic [DW-1:0] d [4];
        int we0, req0, oe0, dir, len, addr;

        rst = 1'b1; bus_in = 1'b1; bus_util = 1'b0; arbiter_grant = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        d = '{8'hA5, 8'h00, 8'h00, 8'h00};
        do_write(16'h0010, 0, d, 1'b0);

        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_read(16'h7FFE, 3, d);

        we0 = we_cnt; req0 = req_cnt; oe0 = oe_cnt;
        send_hdr(5, 1, 0, 16'h0010);
        repeat (4) tick();
        check("skip_oe", bus_oe, 0);
        send_hdr(0, 0, 0, 16'h0005);
        repeat (4) tick();
        check("skip_ignores_frame", bus_oe, 0);
        check("skip_oe_count", oe_cnt - oe0, 0);
        check("skip_we_count", we_cnt - we0, 0);
        check("skip_req_count", req_cnt - req0, 0);
        bus_util = 1'b1;
        tick();
        bus_util = 1'b0;
        d = '{8'h5C, 8'h00, 8'h00, 8'h00};
        do_read(16'h0123, 0, d);

        we0 = we_cnt;
        send_hdr(0, 1, 1, 16'h0100);
        expect_ack();
        write_beat(16'h0100, 8'h3C, 1'b0, 1'b0);
        silent_timeout();
        check("to_we_count", we_cnt - we0, 1);

        send_hdr(0, 1, 0, 16'h0200);
        expect_ack();
        silent_timeout();

        d = '{8'h96, 8'h69, 8'h00, 8'h00};
        do_write(16'h7FFF, 1, d, 1'b1);

        send_hdr(0, 0, 1, 16'h0040);
        expect_ack();
        check("rst_req", mem_req, 1);
        tick();
        mem_rdata = 8'h5A;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        arbiter_grant = 1'b1;
        tick();
        arbiter_grant = 1'b0;
        check("rst_tx_started", bus_oe, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        tick();
        d = '{8'hC3, 8'h00, 8'h00, 8'h00};
        do_write(16'h0777, 0, d, 1'b0);

        for (int t = 0; t < 8; t++) begin
            dir  = $urandom_range(0, 1);
            len  = $urandom_range(0, 3);
            addr = (t % 2 == 0) ? $urandom_range(ASPACE - 3, ASPACE - 1) : $urandom_range(0, ASPACE - 1);
            for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
            if (dir == 1) do_write(addr, len, d, 1'($urandom_range(0, 1)));
            else          do_read(addr, len, d);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (2) tick();
        check("done_total", done_cnt, exp_done);
        check("err_total", err_cnt, exp_err);
        check("done_err_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_bus_slave_burst.md
# serial_bus_slave_burst

Parametrised serial bus slave for the ABruTECH bus. It decodes a serial frame carrying slave ID, direction, burst length and start address. It moves 1..2^BURST_WIDTH data words between the serial line and a local memory port, auto-incrementing the address per beat. It adds burst transfers, configurable ID/address/data widths and a master-silence timeout, which the single-word slave lacks. It sits between the shared serial line and one memory/peripheral.

## Interface
- ID_WIDTH, 3: slave ID field width.
- SELF_ID, 0: this slave's ID.
- ADDR_WIDTH, 15: address field and mem_addr width.
- DATA_WIDTH, 8: data word width.
- BURST_WIDTH, 2: length field width; beats = field+1.
- TIMEOUT, 16: maximum idle cycles waiting for a write-beat start bit.
- clk  in  1  clock. One clock; all logic on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- bus_in  in  1  sampled serial line; idles high.
- bus_out  out  1  value driven onto the line when bus_oe=1.
- bus_oe  out  1  line drive enable. The top level builds the tristate.
- bus_util  in  1  arbiter pulse marking the end of the current bus transaction.
- arbiter_grant  in  1  permission to drive the line (write ack / read data).
- mem_we  out  1  one-cycle write strobe.
- mem_req  out  1  one-cycle read request strobe.
- mem_addr  out  ADDR_WIDTH  current beat address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  memory completion (write done / read data valid).
- busy  out  1  high from the first mem strobe of a transaction until the last mem_ack.
- done  out  1  one-cycle pulse when a burst completes normally.
- err  out  1  one-cycle pulse on timeout abort.

## Operation
- Frame, MSB first: start bit 0, ID[ID_WIDTH], dir (1 = write, 0 = read), len[BURST_WIDTH], addr[ADDR_WIDTH].
- Header length H = 2+ID_WIDTH+BURST_WIDTH+ADDR_WIDTH.
- States:
  - IDLE: bus_in=0 -> HDR.
  - HDR: shift H-1 bits, one per cycle. On the last bit, ID match -> ACK; otherwise -> SKIP.
  - SKIP: stay until bus_util=1, then -> IDLE.
  - ACK: drive 0 for 2 cycles, load mem_addr=addr and beat counter=len. Then write -> WR_WAIT; read -> RD_MEM.
  - WR_WAIT: bus_in=0 -> WR_DATA. Otherwise count; if the count reaches TIMEOUT -> IDLE with err pulse.
  - WR_DATA: shift DATA_WIDTH bits, load mem_wdata, pulse mem_we -> WR_MEM.
  - WR_MEM: wait for mem_ack -> WR_GRANT.
  - WR_GRANT: wait for arbiter_grant -> WR_ACK.
  - WR_ACK: drive 0 for 2 cycles, then 1 for 1 cycle, release. If the beat counter is 0 -> IDLE with done pulse; otherwise decrement the counter, mem_addr+1 -> WR_WAIT.
  - RD_MEM: pulse mem_req on entry; mem_ack latches mem_rdata -> RD_GRANT.
  - RD_GRANT: arbiter_grant -> RD_TX.
  - RD_TX: drive start 0, then DATA_WIDTH bits MSB first, then 1 for 1 cycle, release. If last beat -> IDLE with done pulse; otherwise decrement, mem_addr+1 -> RD_MEM.
- mem_addr increments modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is legal.
- mem_ack is only sampled in WR_MEM/RD_MEM, from the cycle after the strobe onward. It is ignored elsewhere.
- arbiter_grant is only sampled in the *_GRANT states. A grant arriving earlier is ignored and must be re-asserted or held.
- bus_oe=0 in every state except the ACK, WR_ACK and RD_TX drive cycles.

## Timing
- Reset values: bus_oe=0, bus_out=1, mem_we=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, state IDLE.
- rst asserted mid-transaction: the next edge forces reset values, releases the line and discards the burst. There is no err pulse.
- Start bit sampled at cycle 0. Header bits are sampled at cycles 1..H-1. Ack is driven at cycles H and H+1 (cycles 22-23 with defaults).
- Write beat: start bit at cycle s, data bits at s+1..s+DATA_WIDTH, mem_we at s+DATA_WIDTH+1.
- Ack driving starts on the edge after arbiter_grant is sampled.
- Read beat: mem_req on the first RD_MEM cycle; the TX start bit is driven on the edge after grant.
- Timeout: err is asserted exactly TIMEOUT cycles after WR_WAIT entry if bus_in stays high.
- done and err are never asserted together.

## Test plan
- Write, ID 0, len 0, addr 0x0010, data 0xA5 -> ack low at cycles 22-23. mem_we once with mem_addr=0x0010, mem_wdata=0xA5. After mem_ack and grant: line 0,0,1; done pulse.
- Read burst, len 3, addr 0x7FFE, mem_rdata 0x11,0x22,0x33,0x44 -> four mem_req at addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001 (wrap). Serial out per grant: 0 then the byte MSB first; done after the fourth beat.
- ID 5 frame to a SELF_ID=0 slave -> bus_oe stays 0 and there are no mem strobes. The slave returns to IDLE only after a bus_util pulse.
- Write len 1, master silent after beat 1 -> err pulse 16 cycles after WR_WAIT entry; only 1 mem_we; back to IDLE.
- arbiter_grant pulsed before mem_ack -> no line drive; ack only follows a later grant.
- rst asserted during RD_TX -> bus_oe=0 at the next edge, all outputs at reset values, a new frame is accepted afterwards.
